vga_timing_generator: RTL

Source end of the VGA raster interface. Generates the h_count/v_count/new_line triple consumed by display_syncronization, plus the hsync/vsync pins and the active-video qualifier. Runs on the system clock and advances one pixel per pix_ce strobe, so a 50 MHz clk with a divide-by-2 strobe yields standard 640x480@60 timing.

---
 rtl/vga_timing_generator.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_generator.sv
// VGA raster timing source: h/v counters, phase FSMs, syncs, active-video.
// Optional colour-bar output on rgb when VGA_TEST_PATTERN_EN is defined.
module vga_timing_generator #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_ce,
   output logic [9:0]  h_count,
   output logic [9:0]  v_count,
   output logic        new_line,
   output logic        new_frame,
   output logic        hsync,
   output logic        vsync,
   output logic        video_on
`ifdef VGA_TEST_PATTERN_EN
   ,
   output logic [23:0] rgb
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing_generator: H_TOTAL/V_TOTAL exceed 10-bit counters");
   end

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_FS   = 10'(H_ACTIVE);
   localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_BS   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_FS   = 10'(V_ACTIVE);
   localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_BS   = 10'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic [1:0] {
      ST_ACTIVE,
      ST_FRONT,
      ST_SYNC,
      ST_BACK
   } phase_t;

   logic [9:0] r_h_cnt, r_v_cnt;
   phase_t     r_h_st, r_v_st;
   logic       r_hsync, r_vsync, r_video;

   logic [9:0] w_h_nxt, w_v_nxt;
   logic       w_h_last, w_v_last;
   phase_t     w_h_st_nxt, w_v_st_nxt, w_v_st_eff;
   logic       w_video_nxt;

   // >= rather than == so a forced out-of-range count still wraps
   assign w_h_last = (r_h_cnt >= H_LAST);
   assign w_v_last = (r_v_cnt >= V_LAST);
   assign w_h_nxt  = w_h_last ? 10'd0 : r_h_cnt + 10'd1;
   assign w_v_nxt  = w_v_last ? 10'd0 : r_v_cnt + 10'd1;

   always_comb begin
      w_h_st_nxt = r_h_st;
      unique case (1'b1)
         (w_h_nxt == 10'd0): w_h_st_nxt = ST_ACTIVE;
         (w_h_nxt == H_FS):  w_h_st_nxt = ST_FRONT;
         (w_h_nxt == H_SS):  w_h_st_nxt = ST_SYNC;
         (w_h_nxt == H_BS):  w_h_st_nxt = ST_BACK;
         default: ;
      endcase
   end

   always_comb begin
      w_v_st_nxt = r_v_st;
      unique case (1'b1)
         (w_v_nxt == 10'd0): w_v_st_nxt = ST_ACTIVE;
         (w_v_nxt == V_FS):  w_v_st_nxt = ST_FRONT;
         (w_v_nxt == V_SS):  w_v_st_nxt = ST_SYNC;
         (w_v_nxt == V_BS):  w_v_st_nxt = ST_BACK;
         default: ;
      endcase
   end

   assign w_v_st_eff  = w_h_last ? w_v_st_nxt : r_v_st;
   assign w_video_nxt = (w_h_st_nxt == ST_ACTIVE) && (w_v_st_eff == ST_ACTIVE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_h_cnt <= 10'd0;
         r_v_cnt <= 10'd0;
         r_h_st  <= ST_ACTIVE;
         r_v_st  <= ST_ACTIVE;
         r_hsync <= 1'b1;
         r_vsync <= 1'b1;
         r_video <= 1'b1;
      end else if (pix_ce) begin
         r_h_cnt <= w_h_nxt;
         r_h_st  <= w_h_st_nxt;
         r_hsync <= (w_h_st_nxt != ST_SYNC);
         r_video <= w_video_nxt;
         if (w_h_last) begin
            r_v_cnt <= w_v_nxt;
            r_v_st  <= w_v_st_nxt;
            r_vsync <= (w_v_st_nxt != ST_SYNC);
         end
      end
   end

   assign h_count   = r_h_cnt;
   assign v_count   = r_v_cnt;
   assign hsync     = r_hsync;
   assign vsync     = r_vsync;
   assign video_on  = r_video;
   assign new_line  = pix_ce & w_h_last;
   assign new_frame = new_line & w_v_last;

`ifdef VGA_TEST_PATTERN_EN
   localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

   logic [2:0]  w_bar;
   logic [23:0] w_color;
   logic [23:0] r_rgb;

   assign w_bar = 3'(w_h_nxt / BAR_W);

   always_comb begin
      w_color = 24'h000000;
      unique case (w_bar)
         3'd0: w_color = 24'hFFFFFF;
         3'd1: w_color = 24'hFFFF00;
         3'd2: w_color = 24'h00FFFF;
         3'd3: w_color = 24'h00FF00;
         3'd4: w_color = 24'hFF00FF;
         3'd5: w_color = 24'hFF0000;
         3'd6: w_color = 24'h0000FF;
         3'd7: w_color = 24'h000000;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rgb <= 24'h000000;
      end else if (pix_ce) begin
         r_rgb <= w_video_nxt ? w_color : 24'h000000;
      end
   end

   assign rgb = r_rgb;
`endif

endmodule
